// File: rtl/peak_detector_win_if.sv
// Sample/peak bus of the windowed peak detector.
// The sample source owns en/xin and the two runtime settings; the detector
// returns the held peak, its timestamp, the report pulse and the refractory flag.
interface peak_detector_win_if #(
  parameter int DATA_WIDTH = 16,
  parameter int REFRACT_W  = 8,
  parameter int TS_WIDTH   = 32
);
  logic                         en;
  logic signed [DATA_WIDTH-1:0] xin;
  logic signed [DATA_WIDTH-1:0] threshold;
  logic        [REFRACT_W-1:0]  refractory;
  logic signed [DATA_WIDTH-1:0] peak_val;
  logic        [TS_WIDTH-1:0]   peak_ts;
  logic                         peak_valid;
  logic                         peak_update;
  logic                         busy;

  modport master (
    output en, xin, threshold, refractory,
    input  peak_val, peak_ts, peak_valid, peak_update, busy
  );

  modport slave (
    input  en, xin, threshold, refractory,
    output peak_val, peak_ts, peak_valid, peak_update, busy
  );
endinterface

// File: rtl/peak_detector_win.sv
// Windowed local-maximum peak detector for the Pan-Tompkins chain.
// Holds the last 2*HALF_WIN+1 accepted samples; the middle one is a peak when it
// beats every older neighbour strictly, ties-or-beats every newer one, and clears
// the amplitude threshold. After a fresh peak a refractory countdown runs during
// which only strictly larger peaks replace the held one.
module peak_detector_win #(
  parameter int DATA_WIDTH = 16,
  parameter int HALF_WIN   = 2,
  parameter int REFRACT_W  = 8,
  parameter int TS_WIDTH   = 32
) (
  input logic               clk,
  input logic               rstn,
  peak_detector_win_if.slave bus
);

  localparam int D      = 2 * HALF_WIN + 1;
  localparam int FILL_W = $clog2(D + 1);

  typedef enum logic {
    SEARCH,
    REFRACT
  } mode_e;

  // Sample window: sr[0] is the newest accepted sample, sr[D-1] the oldest.
  logic signed [DATA_WIDTH-1:0] sr [D];
  logic        [TS_WIDTH-1:0]   ts;
  logic        [FILL_W-1:0]     fill_cnt;
  logic                         fill;
  logic        [REFRACT_W-1:0]  cnt;

  logic signed [DATA_WIDTH-1:0] peak_val_q;
  logic        [TS_WIDTH-1:0]   peak_ts_q;
  logic                         peak_valid_q;
  logic                         peak_update_q;

  logic signed [DATA_WIDTH-1:0] centre;
  logic        [TS_WIDTH-1:0]   centre_ts;
  logic                         older_ok;
  logic                         newer_ok;
  logic                         candidate;
  mode_e                        mode;

  logic signed [DATA_WIDTH-1:0] peak_val_d;
  logic        [TS_WIDTH-1:0]   peak_ts_d;
  logic                         peak_valid_d;
  logic                         peak_update_d;
  logic        [REFRACT_W-1:0]  cnt_d;

  // Candidate test on the pre-edge window; strict against older samples so the
  // earliest sample of a plateau is the one reported.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    centre    = sr[HALF_WIN];
    centre_ts = ts - TS_WIDTH'(HALF_WIN + 1);
    older_ok  = 1'b1;
    newer_ok  = 1'b1;
    for (int k = 0; k < D; k++) begin
      if (k > HALF_WIN) begin
        if (!(centre > sr[k])) older_ok = 1'b0;
      end else if (k < HALF_WIN) begin
        if (!(centre >= sr[k])) newer_ok = 1'b0;
      end
    end
    candidate = fill && older_ok && newer_ok && (centre >= bus.threshold);
  end

  // Mode is implied by the refractory counter: idle counter means searching.
  always_comb begin
    mode = (cnt == '0) ? SEARCH : REFRACT;
  end

  // Next-state for the peak holder and refractory counter on an accepted sample.
  always_comb begin
    peak_val_d    = peak_val_q;
    peak_ts_d     = peak_ts_q;
    peak_valid_d  = 1'b0;
    peak_update_d = 1'b0;
    cnt_d         = cnt;
    if (bus.en) begin
      case (mode)
        SEARCH: begin
          if (candidate) begin
            peak_val_d    = centre;
            peak_ts_d     = centre_ts;
            peak_valid_d  = 1'b1;
            peak_update_d = 1'b0;
            cnt_d         = bus.refractory;
          end
        end
        REFRACT: begin
          cnt_d = cnt - REFRACT_W'(1);
          if (candidate && (centre > peak_val_q)) begin
            peak_val_d    = centre;
            peak_ts_d     = centre_ts;
            peak_valid_d  = 1'b1;
            peak_update_d = 1'b1;
          end
        end
        default: cnt_d = cnt;
      endcase
    end
  end

  // Sample window, timestamp and warm-up tracking advance only on accepted samples.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: the window is cleared on reset so a restart never compares against stale samples from before it.
      for (int k = 0; k < D; k++) sr[k] <= '0;
      ts       <= '0;
      fill_cnt <= '0;
      fill     <= 1'b0;
    end else if (bus.en) begin
      // NOTE: non-blocking assignments make every stage read its pre-edge neighbour, giving a true shift.
      sr[0] <= bus.xin;
      for (int k = 1; k < D; k++) sr[k] <= sr[k-1];
      ts <= ts + TS_WIDTH'(1);
      if (!fill) begin
        fill_cnt <= fill_cnt + FILL_W'(1);
        if (fill_cnt == FILL_W'(D - 1)) fill <= 1'b1;
      end
    end
  end

  // Peak holder, report pulse and refractory counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      peak_val_q    <= '0;
      peak_ts_q     <= '0;
      peak_valid_q  <= 1'b0;
      peak_update_q <= 1'b0;
      cnt           <= '0;
    end else begin
      peak_val_q    <= peak_val_d;
      peak_ts_q     <= peak_ts_d;
      peak_valid_q  <= peak_valid_d;
      peak_update_q <= peak_update_d;
      cnt           <= cnt_d;
    end
  end

  assign bus.peak_val    = peak_val_q;
  assign bus.peak_ts     = peak_ts_q;
  assign bus.peak_valid  = peak_valid_q;
  assign bus.peak_update = peak_update_q;
  assign bus.busy        = (cnt != '0);

endmodule

// File: tb/tb_peak_detector_win.sv
// Bench for peak_detector_win: two instances (HALF_WIN=1 and 2) share one
// stimulus stream. A reference model working on the raw sample history predicts
// each report into a per-instance queue; monitors pop and compare on peak_valid.
module tb_peak_detector_win;

  localparam int DW = 16;
  localparam int RW = 8;
  localparam int TW = 32;

  typedef struct {
    int val;
    int ts;
    bit upd;
  } exp_t;

  logic clk;
  logic rstn;

  peak_detector_win_if #(.DATA_WIDTH(DW), .REFRACT_W(RW), .TS_WIDTH(TW)) bus1 ();
  peak_detector_win_if #(.DATA_WIDTH(DW), .REFRACT_W(RW), .TS_WIDTH(TW)) bus2 ();

  peak_detector_win #(.DATA_WIDTH(DW), .HALF_WIN(1), .REFRACT_W(RW), .TS_WIDTH(TW)) u_dut1 (
    .clk (clk),
    .rstn(rstn),
    .bus (bus1)
  );

  peak_detector_win #(.DATA_WIDTH(DW), .HALF_WIN(2), .REFRACT_W(RW), .TS_WIDTH(TW)) u_dut2 (
    .clk (clk),
    .rstn(rstn),
    .bus (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  exp_t q1[$];
  exp_t q2[$];
  int   hist[$];
  int   m_cnt[2];
  int   m_peak[2];
  bit   exp_busy[2];
  int   cur_thr;
  int   cur_refr;
  int   stim[$];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Window rule straight from the sample history: centre is the sample HALF_WIN
  // back from the newest; strictly above older ones, at least the newer ones.
  function automatic bit is_candidate(input int hw, output int cv, output int ci);
    int n;
    n  = hist.size();
    cv = 0;
    ci = 0;
    if (n < 2 * hw + 1) return 1'b0;
    ci = n - 1 - hw;
    cv = hist[ci];
    for (int j = 1; j <= hw; j++) begin
      if (cv <= hist[ci-j]) return 1'b0;
      if (cv <  hist[ci+j]) return 1'b0;
    end
    return cv >= cur_thr;
  endfunction

  task automatic drive(input bit e, input int x);
    bus1.en = e;  bus1.xin = DW'(x);  bus1.threshold = DW'(cur_thr);  bus1.refractory = RW'(cur_refr);
    bus2.en = e;  bus2.xin = DW'(x);  bus2.threshold = DW'(cur_thr);  bus2.refractory = RW'(cur_refr);
  endtask

  task automatic step(input bit e, input int x);
    exp_t pend[2];
    bit   has[2];
    has = '{1'b0, 1'b0};
    drive(e, x);
    if (e) begin
      for (int i = 0; i < 2; i++) begin
        int cv;
        int ci;
        bit c;
        c = is_candidate(i + 1, cv, ci);
        if (m_cnt[i] == 0) begin
          if (c) begin
            has[i]    = 1'b1;
            pend[i]   = '{cv, ci, 1'b0};
            m_peak[i] = cv;
            m_cnt[i]  = cur_refr;
          end
        end else begin
          m_cnt[i]--;
          if (c && cv > m_peak[i]) begin
            has[i]    = 1'b1;
            pend[i]   = '{cv, ci, 1'b1};
            m_peak[i] = cv;
          end
        end
      end
      hist.push_back(x);
    end
    @(posedge clk);
    #1;
    if (has[0]) q1.push_back(pend[0]);
    if (has[1]) q2.push_back(pend[1]);
    for (int i = 0; i < 2; i++) exp_busy[i] = (m_cnt[i] != 0);
  endtask

  task automatic run_stream(input int s[$], input int gap);
    foreach (s[i]) begin
      step(1'b1, s[i]);
      for (int g = 0; g < gap; g++) step(1'b0, int'($urandom_range(200)) - 100);
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_val1"}, longint'(bus1.peak_val), 0);
    check({tag, "_ts1"}, longint'(bus1.peak_ts), 0);
    check({tag, "_valid1"}, longint'(bus1.peak_valid), 0);
    check({tag, "_upd1"}, longint'(bus1.peak_update), 0);
    check({tag, "_busy1"}, longint'(bus1.busy), 0);
    check({tag, "_val2"}, longint'(bus2.peak_val), 0);
    check({tag, "_ts2"}, longint'(bus2.peak_ts), 0);
    check({tag, "_busy2"}, longint'(bus2.busy), 0);
  endtask

  // Called just after an active edge; waits past the pending monitor sample,
  // resets both instances and the model, and realigns to just after an edge.
  task automatic do_reset(input string tag);
    drive(1'b0, 0);
    #5;
    rstn = 1'b0;
    hist.delete();
    q1.delete();
    q2.delete();
    m_cnt    = '{0, 0};
    m_peak   = '{0, 0};
    exp_busy = '{1'b0, 1'b0};
    #1;
    check_cleared(tag);
    #2;
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Monitors: compare each reported peak with the oldest prediction and track busy.
  always @(negedge clk) begin
    if (rstn) begin
      if (bus1.peak_valid) begin
        if (q1.size() == 0) check("hw1_unexpected_pulse", longint'(bus1.peak_valid), 0);
        else begin
          exp_t e;
          e = q1.pop_front();
          check("hw1_peak_val", longint'(bus1.peak_val), longint'(e.val));
          check("hw1_peak_ts", longint'(bus1.peak_ts), longint'(e.ts));
          check("hw1_peak_update", longint'(bus1.peak_update), longint'(e.upd));
        end
      end
      check("hw1_busy", longint'(bus1.busy), longint'(exp_busy[0]));
    end
  end

  always @(negedge clk) begin
    if (rstn) begin
      if (bus2.peak_valid) begin
        if (q2.size() == 0) check("hw2_unexpected_pulse", longint'(bus2.peak_valid), 0);
        else begin
          exp_t e;
          e = q2.pop_front();
          check("hw2_peak_val", longint'(bus2.peak_val), longint'(e.val));
          check("hw2_peak_ts", longint'(bus2.peak_ts), longint'(e.ts));
          check("hw2_peak_update", longint'(bus2.peak_update), longint'(e.upd));
        end
      end
      check("hw2_busy", longint'(bus2.busy), longint'(exp_busy[1]));
    end
  end

  initial begin
    rstn     = 1'b1;
    cur_thr  = 10;
    cur_refr = 0;
    m_cnt    = '{0, 0};
    m_peak   = '{0, 0};
    exp_busy = '{1'b0, 1'b0};
    drive(1'b0, 0);
    #1 rstn = 1'b0;
    #2 check_cleared("por");
    #9 rstn = 1'b1;
    @(posedge clk);
    #1;

    // Single peak, no refractory.
    stim = {0, 0, 20, 5, 0, 0};
    run_stream(stim, 0);
    check("single_val", longint'(bus1.peak_val), 20);
    check("single_ts", longint'(bus1.peak_ts), 2);

    // Plateau: earliest sample of the flat top wins.
    do_reset("rst_plateau");
    stim = {0, 0, 7, 15, 15, 3, 0};
    run_stream(stim, 0);
    check("plateau_val", longint'(bus1.peak_val), 15);
    check("plateau_ts", longint'(bus1.peak_ts), 3);

    // Below threshold: nothing reported.
    do_reset("rst_below");
    stim = {0, 8, 0, 0};
    run_stream(stim, 0);
    check("below_val", longint'(bus1.peak_val), 0);

    // Negative threshold, signed compare.
    do_reset("rst_neg");
    cur_thr = -5;
    stim = {-20, -3, -20, -20};
    run_stream(stim, 0);
    check("neg_val", longint'(bus1.peak_val), -3);
    check("neg_ts", longint'(bus1.peak_ts), 1);

    // Refractory: 20 fresh, 30 replaces, 25 ignored, 12 fresh after expiry.
    do_reset("rst_refr");
    cur_thr  = 10;
    cur_refr = 4;
    stim = {0, 0, 20, 0, 30, 0, 25, 0, 0, 0, 12, 0, 0};
    run_stream(stim, 0);
    check("refr_val", longint'(bus1.peak_val), 12);
    check("refr_ts", longint'(bus1.peak_ts), 10);

    // Same stream with idle gaps between samples.
    do_reset("rst_gap");
    run_stream(stim, 5);
    check("gap_val", longint'(bus1.peak_val), 12);
    check("gap_ts", longint'(bus1.peak_ts), 10);

    // Warm-up: index 0 has no older neighbours and is never reported.
    do_reset("rst_warm");
    stim = {50, 0, 0, 0, 0};
    run_stream(stim, 0);
    check("warm_val2", longint'(bus2.peak_val), 0);
    check("warm_val1", longint'(bus1.peak_val), 0);

    // Reset in the middle of a refractory period; timestamps restart.
    do_reset("rst_pre_mid");
    cur_refr = 10;
    stim = {0, 0, 20, 0, 0};
    run_stream(stim, 0);
    check("mid_busy_before", longint'(bus1.busy), 1);
    do_reset("rst_mid");
    stim = {0, 30, 0, 0};
    run_stream(stim, 0);
    check("mid_after_val", longint'(bus1.peak_val), 30);
    check("mid_after_ts", longint'(bus1.peak_ts), 1);

    // Randomised traffic with changing settings and one reset partway through.
    do_reset("rst_rand");
    for (int n = 0; n < 900; n++) begin
      if (n % 60 == 0) begin
        cur_thr  = int'($urandom_range(40)) - 10;
        cur_refr = int'($urandom_range(6));
      end
      if (n == 450) do_reset("rst_rand_mid");
      step($urandom_range(3) != 0, int'($urandom_range(100)) - 50);
    end

    step(1'b0, 0);
    #5;
    check("hw1_drain", longint'(q1.size()), 0);
    check("hw2_drain", longint'(q2.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/peak_detector_win.md
Name: peak_detector_win

Overview:
Parametrised successor of the 3-tap local-maximum peak detector in the Pan-Tompkins chain, sitting after the moving-window integrator. It finds local maxima over a configurable (2*HALF_WIN+1)-sample window and qualifies them against a runtime amplitude threshold. It applies a runtime refractory period during which only larger peaks replace the held one. Each reported peak is emitted as a one-cycle pulse with value and sample timestamp.

Parameters:
DATA_WIDTH, 16, signed sample width
HALF_WIN, 2, samples each side of centre; window depth D = 2*HALF_WIN+1 (HALF_WIN >= 1)
REFRACT_W, 8, width of refractory length/counter
TS_WIDTH, 32, width of sample timestamp counter

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-low
en  in  1  sample strobe; one sample accepted per clk with en=1
xin  in  DATA_WIDTH  signed input sample
threshold  in  DATA_WIDTH  signed minimum peak amplitude
refractory  in  REFRACT_W  refractory length in accepted samples, sampled at detection
peak_val  out  DATA_WIDTH  signed value of last reported peak
peak_ts  out  TS_WIDTH  sample index of last reported peak
peak_valid  out  1  one-cycle pulse: new peak reported
peak_update  out  1  qualifies peak_valid: 1 = replacement within refractory, 0 = fresh peak
busy  out  1  refractory active (cnt != 0)

Behaviour:
- Reset: sr[*], ts, cnt, fill flag, peak_val, peak_ts, peak_valid, peak_update = 0; busy = 0.
- en=0: all state frozen; peak_valid/peak_update drop to 0 next edge; peak_val/peak_ts hold.
- en=1 edge: sr[0]<=xin, sr[k]<=sr[k-1], ts<=ts+1 (wraps mod 2^TS_WIDTH). The first sample accepted after reset is index 0.
- Evaluation uses pre-edge contents: sr[k] = sample index ts-1-k; centre c = sr[HALF_WIN], index ts-1-HALF_WIN (mod 2^TS_WIDTH).
- Fill flag: set once D samples have been accepted; sticky until reset. No detection before it is set.
- Candidate (signed compares): fill set AND c > sr[k] for all k > HALF_WIN (older) AND c >= sr[k] for all k < HALF_WIN (newer) AND c >= threshold. On a plateau the earliest sample wins.
- Latency: sample n is reported at the edge accepting sample n+HALF_WIN+1; peak_valid is high for the following cycle.
- Mode SEARCH (cnt==0): a candidate latches peak_val=c and peak_ts=centre index, pulses peak_valid with peak_update=0, and loads cnt<=refractory. If refractory=0, the block stays in SEARCH.
- Mode REFRACT (cnt!=0): each en edge cnt<=cnt-1. A candidate with c > peak_val (strict) latches value/ts and pulses peak_valid with peak_update=1; cnt is not reloaded. A candidate with c <= peak_val is ignored.
- Simultaneous: the edge where cnt goes 1->0 still evaluates as REFRACT. The next en edge evaluates as SEARCH.
- threshold changes apply immediately. refractory changes take effect only at the next SEARCH detection.
- Reset mid-operation: all state cleared; the fill period restarts and ts restarts at 0.

Test Plan:
- HALF_WIN=1, threshold=10, refractory=0; stream 0,0,20,5,0,0 -> peak_valid one cycle after edge accepting index 4; peak_val=20, peak_ts=2, peak_update=0.
- Plateau 0,0,7,15,15,3,0 (threshold=10) -> one report: peak_val=15, peak_ts=3. Index 4 rejected (not > older).
- Below threshold: 0,8,0,0 with threshold=10 -> no peak_valid. With threshold=-5, stream -20,-3,-20,-20 -> peak_val=-3 (signed compare).
- Refractory=4: peaks 20@2, 30@4, 25@6 -> pulses for 20 (update=0) and 30 (update=1). 25 ignored. busy clears 4 accepted samples after first detection, and a later 12@10 reports with update=0.
- en gating: insert 5 idle cycles (en=0) between samples -> identical peak_val/peak_ts, no extra pulses, cnt frozen while idle.
- Warm-up/reset: HALF_WIN=2, stream 50,0,0,0,0 from reset -> no report (index 0 lacks older neighbours). Assert rstn low mid-refractory -> all outputs 0, busy 0; the next peak reports with ts relative to the new index 0.
